regfile_wb_arbiter: RTL

//  Sole writer of the regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).

---
 rtl/rf_pkg.sv | 15 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared widths and the write-port request payload for the regfile writeback path.
package rf_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  // One regfile write request: enable, destination register, data.
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_req_t holding multdiv results until they win the write port.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clock,
  input  logic    ctrl_reset,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Push is allowed when full only if a pop frees the slot in the same cycle.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner: arbitrates pipeline writeback against queued multdiv
// results, tracks in-flight multdiv destinations, and stalls the pipe when the
// result FIFO is starved.
// Optional: define RF_WB_FWD_EN to add a forwarding port off the registered write.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned MD_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_rd,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              wb_stall,
  output logic [NUM_REGS-1:0] busy,
`ifdef RF_WB_FWD_EN
  input  logic [REG_W-1:0]  fwd_rs_a,
  input  logic [REG_W-1:0]  fwd_rs_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
`endif
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t               wr_q, wr_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  stall_q, stall_d;

  logic                  fifo_full, fifo_empty;
  wb_req_t               fifo_head;
  wb_req_t               push_req;
  logic                  pipe_sel, pop_sel, push_en;

  assign push_req = '{we: 1'b1, rd: md_rd, data: md_data};

  wb_fifo #(
    .DEPTH (MD_FIFO_DEPTH)
  ) u_md_fifo (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .push_i      (push_en),
    .push_data_i (push_req),
    .pop_i       (pop_sel),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Port arbitration, scoreboard update and starvation tracking.
  always_comb begin
    pipe_sel = pipe_we && (pipe_rd != '0) && !stall_q;
    pop_sel  = !pipe_sel && !fifo_empty;
    push_en  = md_valid && !fifo_full && (md_rd != '0);

    wr_d = '0;
    if (pipe_sel) begin
      wr_d = '{we: 1'b1, rd: pipe_rd, data: pipe_data};
    end else if (pop_sel) begin
      wr_d = fifo_head;
    end

    // Clear first so a same-cycle issue to the same register keeps it busy.
    busy_d = busy_q;
    if (pop_sel) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (md_issue) begin
      busy_d[md_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    starve_d = '0;
    stall_d  = 1'b0;
    if (fifo_full && pipe_sel) begin
      if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Registered write port, scoreboard and stall pulse.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_q     <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign md_ready         = !fifo_full;
  assign wb_stall         = stall_q;
  assign busy             = busy_q;
  assign ctrl_writeEnable = wr_q.we;
  assign ctrl_writeReg    = wr_q.rd;
  assign data_writeReg    = wr_q.data;

`ifdef RF_WB_FWD_EN
  // Forward the value sitting on the write port before the regfile commits it.
  assign fwd_hit_a  = wr_q.we && (wr_q.rd == fwd_rs_a) && (fwd_rs_a != '0);
  assign fwd_hit_b  = wr_q.we && (wr_q.rd == fwd_rs_b) && (fwd_rs_b != '0);
  assign fwd_data_a = wr_q.data;
  assign fwd_data_b = wr_q.data;
`endif

endmodule
